spi_slave: RTL and testbench
============================

SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 SHALL have parameter RESET_MEM, default 8'h00, the slave memory value after reset.
REQ-002 SHALL have parameter CS_IDX, default 1, the chip-select number (1..3) this instance answers, for documentation and bench binding only.
REQ-003 SHALL have port clk, input, 1, the serial clock driven by the master; the block's only clock.
REQ-004 SHALL have port rst, input, 1; reset is synchronous and active-high.
REQ-005 SHALL have port CS, input, 1, active-low chip select.
REQ-006 SHALL have port MOSI, input, 1, master-to-slave serial data, MSB first.
REQ-007 SHALL have port MISO, output, 1, slave-to-master serial data, MSB first.
REQ-008 SHALL have port mem_q, output, 8, current slave memory.
REQ-009 SHALL have port cmd_q, output, 8, last fully received command byte.
REQ-010 SHALL have port frame_done, output, 1, one-cycle pulse on frame commit.
REQ-011 SHALL have port busy, output, 1, high while in CMD or DATA state.
REQ-012 SHALL have port err, output, 1, sticky illegal-command flag (see Configuration).

Function
REQ-013 SHALL implement states IDLE, CMD, DATA, HOLD with a 4-bit bit counter.
REQ-014 SHALL, in IDLE, on a rising clk edge with CS low, sample MOSI as command bit 7, set counter to 1, and enter CMD.
REQ-015 SHALL, in CMD, shift MOSI into a command shift register each edge; on the 8th command bit, load cmd_q and enter DATA with counter 0.
REQ-016 SHALL decode commands as: 8'h01 READ, 8'h02 WRITE, 8'h03 EXCHANGE; all other values are NOP.
REQ-017 SHALL copy mem_q into a transmit shift register on entry to DATA; MISO SHALL equal that register's bit 7 during DATA for READ/EXCHANGE and be 0 in every other state or command.
REQ-018 SHALL, in DATA, rotate the transmit register left on each edge, and for WRITE/EXCHANGE shift MOSI into a receive shift register.
REQ-019 SHALL, on the 8th data edge, commit: WRITE/EXCHANGE load mem_q from the receive register (including the 8th bit); READ/NOP leave mem_q unchanged. It SHALL then pulse frame_done and enter HOLD.
REQ-020 SHALL assert frame_done for exactly the one cycle following the commit edge.
REQ-021 SHALL remain in HOLD, ignoring MOSI, until CS is sampled high, then enter IDLE.
REQ-022 SHALL, on CS sampled high in CMD or DATA, abort to IDLE with mem_q, cmd_q, and err unchanged and no frame_done.
REQ-023 SHALL, if rst and CS-low both occur on the same edge, give rst priority.
REQ-024 SHALL keep the bit counter from wrapping; a frame is exactly 16 bits, and extra bits fall in HOLD.

Reset
REQ-025 SHALL, on rst high at a rising edge, set the state to IDLE, counter to 0, mem_q to RESET_MEM, cmd_q to 8'h00, and all shift registers to 0.
REQ-026 SHALL hold frame_done, busy, err, and MISO at 0 during and immediately after reset.
REQ-027 SHALL honour rst mid-frame, discarding partial data with no commit.

Configuration
REQ-028 SHALL, with SPI_SLAVE_CMD_ERR_EN defined, set err on receipt of a NOP-class command; err SHALL clear only on rst.
REQ-029 SHALL, without SPI_SLAVE_CMD_ERR_EN, tie err to 0 and remove its flop; NOP handling is otherwise identical.

Structure
REQ-030 SHALL take CMD_READ, CMD_WRITE, CMD_EXCHANGE constants and the state enum from shared package spi_pkg, which the master SHALL also use.
REQ-031 SHALL instantiate the 8-bit shift/rotate register as sub-module spi_shift8 (load, shift-in, rotate modes) for the command, transmit, and receive registers.

Verification
REQ-032 SHALL cover WRITE: RESET_MEM=00, frame 02 then 4D -> mem_q=4D, frame_done once, MISO=0 throughout.
REQ-033 SHALL cover READ: mem_q=A5, frame 01 then FF -> MISO bits 1,0,1,0,0,1,0,1 in DATA, mem_q stays A5.
REQ-034 SHALL cover EXCHANGE: mem_q=3C, MOSI data C3 -> MISO shows 3C, and after commit mem_q=C3.
REQ-035 SHALL cover abort: frame 02 with CS raised after 11 bits -> mem_q unchanged, no frame_done, state IDLE.
REQ-036 SHALL cover illegal command: frame 7E -> mem_q unchanged, err=1 with SPI_SLAVE_CMD_ERR_EN defined, err=0 without.
REQ-037 SHALL cover reset mid-DATA: rst at data bit 4 -> mem_q=RESET_MEM, busy=0, and the next frame works normally.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared SPI definitions: command codes, slave FSM states and shift-register modes.
package spi_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned CNT_W  = 4;

  localparam logic [DATA_W-1:0] CMD_READ     = 8'h01;
  localparam logic [DATA_W-1:0] CMD_WRITE    = 8'h02;
  localparam logic [DATA_W-1:0] CMD_EXCHANGE = 8'h03;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    DATA = 2'd2,
    HOLD = 2'd3
  } spi_state_t;

  typedef enum logic [1:0] {
    SH_HOLD  = 2'd0,
    SH_LOAD  = 2'd1,
    SH_SHIFT = 2'd2,
    SH_ROT   = 2'd3
  } shift_mode_t;

  // Commands whose data phase captures MOSI into memory
  function automatic logic is_rx_cmd(input logic [DATA_W-1:0] c);
    return (c == CMD_WRITE) || (c == CMD_EXCHANGE);
  endfunction

  // Commands whose data phase drives memory contents onto MISO
  function automatic logic is_tx_cmd(input logic [DATA_W-1:0] c);
    return (c == CMD_READ) || (c == CMD_EXCHANGE);
  endfunction

  // Anything that is not READ, WRITE or EXCHANGE
  function automatic logic is_nop_cmd(input logic [DATA_W-1:0] c);
    return !(is_rx_cmd(c) || is_tx_cmd(c));
  endfunction

endpackage

// File: rtl/spi_shift8.sv
// 8-bit register with hold, parallel load, MSB-first shift-in and rotate-left modes.
module spi_shift8
  import spi_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  shift_mode_t       mode,
  input  logic [DATA_W-1:0] d,
  input  logic              si,
  output logic [DATA_W-1:0] q
);

  // Register update selected by mode
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else begin
      case (mode)
        SH_LOAD:  q <= d;
        SH_SHIFT: q <= {q[DATA_W-2:0], si};
        SH_ROT:   q <= {q[DATA_W-2:0], q[DATA_W-1]};
        default:  q <= q;
      endcase
    end
  end

endmodule

// File: rtl/spi_slave.sv
// SPI slave: 8-bit command byte followed by 8-bit data byte, MSB first, on one 8-bit memory.
// Optional feature macro: SPI_SLAVE_CMD_ERR_EN (sticky err flag on NOP-class commands).
module spi_slave
  import spi_pkg::*;
#(
  parameter logic [7:0]  RESET_MEM = 8'h00,
  parameter int unsigned CS_IDX    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              CS,
  input  logic              MOSI,
  output logic              MISO,
  output logic [DATA_W-1:0] mem_q,
  output logic [DATA_W-1:0] cmd_q,
  output logic              frame_done,
  output logic              busy,
  output logic              err
);

  // Chip-select index only identifies the instance to the surrounding system
  localparam logic [1:0] unused_cs_idx = 2'(CS_IDX);

  spi_state_t        state;
  logic [CNT_W-1:0]  cnt;
  logic              tx_en;
  logic [DATA_W-1:0] cmd_sh;
  logic [DATA_W-1:0] tx_sh;
  logic [DATA_W-1:0] rx_sh;
  shift_mode_t       cmd_mode;
  shift_mode_t       tx_mode;
  shift_mode_t       rx_mode;
  logic              last_bit_c;
  logic [DATA_W-1:0] cmd_word_c;
  logic [DATA_W-1:0] rx_word_c;
  logic              unused_bits;

  assign last_bit_c  = (cnt == CNT_W'(DATA_W - 1));
  // Completed bytes include the bit being sampled on this edge
  assign cmd_word_c  = {cmd_sh[DATA_W-2:0], MOSI};
  assign rx_word_c   = {rx_sh[DATA_W-2:0], MOSI};
  assign MISO        = tx_en & tx_sh[DATA_W-1];
  assign unused_bits = ^{cmd_sh[DATA_W-1], rx_sh[DATA_W-1], tx_sh[DATA_W-2:0]};

  spi_shift8 u_cmd_sh (
    .clk  (clk),
    .rst  (rst),
    .mode (cmd_mode),
    .d    ('0),
    .si   (MOSI),
    .q    (cmd_sh)
  );

  spi_shift8 u_tx_sh (
    .clk  (clk),
    .rst  (rst),
    .mode (tx_mode),
    .d    (mem_q),
    .si   (1'b0),
    .q    (tx_sh)
  );

  spi_shift8 u_rx_sh (
    .clk  (clk),
    .rst  (rst),
    .mode (rx_mode),
    .d    ('0),
    .si   (MOSI),
    .q    (rx_sh)
  );

  // Shift-register mode selection from the current state and chip select
  always_comb begin
    cmd_mode = SH_HOLD;
    tx_mode  = SH_HOLD;
    rx_mode  = SH_HOLD;
    if (!CS) begin
      case (state)
        IDLE: cmd_mode = SH_SHIFT;
        CMD: begin
          cmd_mode = SH_SHIFT;
          if (last_bit_c) tx_mode = SH_LOAD;
        end
        DATA: begin
          tx_mode = SH_ROT;
          if (is_rx_cmd(cmd_q)) rx_mode = SH_SHIFT;
        end
        default: ;
      endcase
    end
  end

  // Frame FSM with bit counter, memory commit and registered status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      mem_q      <= RESET_MEM;
      cmd_q      <= '0;
      frame_done <= 1'b0;
      busy       <= 1'b0;
      tx_en      <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (!CS) begin
            state <= CMD;
            cnt   <= CNT_W'(1);
            busy  <= 1'b1;
          end
        end
        CMD: begin
          if (CS) begin
            state <= IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
          end else if (last_bit_c) begin
            cmd_q <= cmd_word_c;
            state <= DATA;
            cnt   <= '0;
            tx_en <= is_tx_cmd(cmd_word_c);
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DATA: begin
          if (CS) begin
            state <= IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
            tx_en <= 1'b0;
          end else if (last_bit_c) begin
            if (is_rx_cmd(cmd_q)) mem_q <= rx_word_c;
            frame_done <= 1'b1;
            state      <= HOLD;
            busy       <= 1'b0;
            tx_en      <= 1'b0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        HOLD: begin
          if (CS) begin
            state <= IDLE;
            cnt   <= '0;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
          busy  <= 1'b0;
          tx_en <= 1'b0;
        end
      endcase
    end
  end

`ifdef SPI_SLAVE_CMD_ERR_EN
  // Sticky flag raised when a complete command byte decodes as NOP
  always_ff @(posedge clk) begin
    if (rst) begin
      err <= 1'b0;
    end else if (state == CMD && !CS && last_bit_c && is_nop_cmd(cmd_word_c)) begin
      err <= 1'b1;
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_spi_slave.sv
// Directed self-checking bench for spi_slave (honours SPI_SLAVE_CMD_ERR_EN).
module tb_spi_slave;
  import spi_pkg::*;

`ifdef SPI_SLAVE_CMD_ERR_EN
  localparam logic ERR_EXP = 1'b1;
`else
  localparam logic ERR_EXP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       CS;
  logic       MOSI;
  logic       MISO;
  logic [7:0] mem_q;
  logic [7:0] cmd_q;
  logic       frame_done;
  logic       busy;
  logic       err;

  int         errors = 0;
  int         checks = 0;
  int         done_total = 0;
  int         miso_hi;
  int         d0;
  logic [7:0] miso_cap;
  logic       busy_mid;
  logic       fd1;
  logic       fd2;

  spi_slave #(.RESET_MEM(8'h00), .CS_IDX(1)) dut (
    .clk        (clk),
    .rst        (rst),
    .CS         (CS),
    .MOSI       (MOSI),
    .MISO       (MISO),
    .mem_q      (mem_q),
    .cmd_q      (cmd_q),
    .frame_done (frame_done),
    .busy       (busy),
    .err        (err)
  );

  always #5 clk = ~clk;

  // Count every cycle in which frame_done is seen high
  always @(negedge clk) if (frame_done) done_total++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive nbits MSB-first from a 24-bit vector with CS low; capture MISO over data bits
  task automatic frame(input logic [23:0] bits, input int nbits);
    miso_hi  = 0;
    miso_cap = 8'h00;
    busy_mid = 1'b0;
    for (int b = 0; b < nbits; b++) begin
      @(negedge clk);
      if (b == 3) busy_mid = busy;
      if (b >= 8 && b < 16) miso_cap = {miso_cap[6:0], MISO};
      else if (MISO) miso_hi++;
      CS   = 1'b0;
      MOSI = bits[23-b];
    end
  endtask

  // Let the last driven edge happen, then raise CS for one edge
  task automatic end_frame();
    @(negedge clk);
    fd1 = frame_done;
    if (MISO) miso_hi++;
    CS   = 1'b1;
    MOSI = 1'b0;
    @(negedge clk);
    fd2 = frame_done;
    if (MISO) miso_hi++;
  endtask

  initial begin
    rst  = 1'b1;
    CS   = 1'b1;
    MOSI = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_mem", 32'(mem_q), 32'h00);
    chk("rst_cmd", 32'(cmd_q), 32'h00);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(frame_done), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    chk("rst_miso", 32'(MISO), 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // WRITE 4D
    d0 = done_total;
    frame({8'h02, 8'h4D, 8'h00}, 16);
    end_frame();
    chk("wr_mem", 32'(mem_q), 32'h4D);
    chk("wr_cmd", 32'(cmd_q), 32'h02);
    chk("wr_busy_mid", 32'(busy_mid), 32'h1);
    chk("wr_fd_pulse", 32'(fd1), 32'h1);
    chk("wr_fd_after", 32'(fd2), 32'h0);
    chk("wr_done_cnt", 32'(done_total - d0), 32'd1);
    chk("wr_miso_data", 32'(miso_cap), 32'h00);
    chk("wr_miso_other", 32'(miso_hi), 32'd0);

    // WRITE A5 followed by extra bits that must fall in HOLD
    d0 = done_total;
    frame({8'h02, 8'hA5, 8'hF0}, 20);
    end_frame();
    chk("extra_mem", 32'(mem_q), 32'hA5);
    chk("extra_done_cnt", 32'(done_total - d0), 32'd1);
    chk("extra_busy", 32'(busy), 32'h0);

    // READ with mem A5
    d0 = done_total;
    frame({8'h01, 8'hFF, 8'h00}, 16);
    end_frame();
    chk("rd_miso", 32'(miso_cap), 32'hA5);
    chk("rd_mem", 32'(mem_q), 32'hA5);
    chk("rd_cmd", 32'(cmd_q), 32'h01);
    chk("rd_fd_pulse", 32'(fd1), 32'h1);
    chk("rd_miso_other", 32'(miso_hi), 32'd0);

    // EXCHANGE: mem 3C, MOSI C3
    frame({8'h02, 8'h3C, 8'h00}, 16);
    end_frame();
    chk("ex_pre_mem", 32'(mem_q), 32'h3C);
    frame({8'h03, 8'hC3, 8'h00}, 16);
    end_frame();
    chk("ex_miso", 32'(miso_cap), 32'h3C);
    chk("ex_mem", 32'(mem_q), 32'hC3);

    // Abort after 11 bits of a WRITE
    d0 = done_total;
    frame({8'h02, 8'h00, 8'h00}, 11);
    end_frame();
    chk("ab_mem", 32'(mem_q), 32'hC3);
    chk("ab_done_cnt", 32'(done_total - d0), 32'd0);
    chk("ab_busy", 32'(busy), 32'h0);
    chk("ab_state", 32'(dut.state), 32'(IDLE));
    chk("ab_cmd", 32'(cmd_q), 32'h02);
    chk("ab_err", 32'(err), 32'h0);

    // Illegal command 7E
    d0 = done_total;
    frame({8'h7E, 8'h55, 8'h00}, 16);
    end_frame();
    chk("nop_mem", 32'(mem_q), 32'hC3);
    chk("nop_cmd", 32'(cmd_q), 32'h7E);
    chk("nop_err", 32'(err), 32'(ERR_EXP));
    chk("nop_done_cnt", 32'(done_total - d0), 32'd1);
    chk("nop_miso", 32'(miso_hi) + 32'(miso_cap), 32'd0);

    // Reset at data bit 4 of a WRITE
    d0 = done_total;
    frame({8'h02, 8'hFF, 8'h00}, 12);
    @(negedge clk);
    rst  = 1'b1;
    MOSI = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    CS  = 1'b1;
    chk("mr_mem", 32'(mem_q), 32'h00);
    chk("mr_busy", 32'(busy), 32'h0);
    chk("mr_cmd", 32'(cmd_q), 32'h00);
    chk("mr_err", 32'(err), 32'h0);
    chk("mr_miso", 32'(MISO), 32'h0);
    chk("mr_done_cnt", 32'(done_total - d0), 32'd0);
    @(negedge clk);

    // Normal frame after mid-frame reset
    d0 = done_total;
    frame({8'h02, 8'h5A, 8'h00}, 16);
    end_frame();
    chk("post_mem", 32'(mem_q), 32'h5A);
    chk("post_done_cnt", 32'(done_total - d0), 32'd1);
    chk("post_state", 32'(dut.state), 32'(IDLE));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
